// File: rtl/mips_pkg.sv
// Shared datapath sizing and constants for the MIPS write-back / register-file slice.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;

    // Index of the hard-wired $zero register
    localparam int REG_ZERO   = 0;

    // Size check usable from any module that re-parameterises the register file
    function automatic bit regfile_size_ok(input int addr_width, input int num_regs);
        return (2 ** addr_width) == num_regs;
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Write-back select: load data or ALU result onto the commit/forwarding bus.
module wb_mux
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] WB_ReadData,
    input  logic [DATA_WIDTH-1:0] WB_ALU_result,
    input  logic                  WB_MemtoReg,
    output logic [DATA_WIDTH-1:0] WB_WriteData
);

    always_comb begin
        WB_WriteData = WB_MemtoReg ? WB_ReadData : WB_ALU_result;
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file with two async read ports.
// Optional macro REGFILE_BYPASS_EN adds a write-through path from WB_WriteData to the read ports.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = mips_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] WB_ReadData,
    input  logic [DATA_WIDTH-1:0] WB_ALU_result,
    input  logic [ADDR_WIDTH-1:0] WB_RegDest,
    input  logic                  WB_MemtoReg,
    input  logic                  WB_RegWrite,
    input  logic [ADDR_WIDTH-1:0] ID_ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ID_ReadReg2,
    output logic [DATA_WIDTH-1:0] ID_ReadData1,
    output logic [DATA_WIDTH-1:0] ID_ReadData2,
    output logic [DATA_WIDTH-1:0] WB_WriteData
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
    localparam bit SIZE_OK = regfile_size_ok(ADDR_WIDTH, NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] arr_rd1;
    logic [DATA_WIDTH-1:0] arr_rd2;

    wb_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wb_mux (
        .WB_ReadData   (WB_ReadData),
        .WB_ALU_result (WB_ALU_result),
        .WB_MemtoReg   (WB_MemtoReg),
        .WB_WriteData  (WB_WriteData)
    );

    // RegWrite is checked first so an undefined destination on an idle cycle cannot select an entry
    always_comb begin
        wr_en = 1'b0;
        if (WB_RegWrite == 1'b1) begin
            wr_en = SIZE_OK && (WB_RegDest != ZERO_IDX);
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WB_RegDest] = WB_WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Entry 0 is masked on read so $zero holds even before the first reset edge
    always_comb begin
        arr_rd1 = (ID_ReadReg1 == ZERO_IDX) ? '0 : regs_q[ID_ReadReg1];
        arr_rd2 = (ID_ReadReg2 == ZERO_IDX) ? '0 : regs_q[ID_ReadReg2];
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1;
    logic byp2;

    always_comb begin
        byp1         = wr_en && !rst && (WB_RegDest == ID_ReadReg1);
        byp2         = wr_en && !rst && (WB_RegDest == ID_ReadReg2);
        ID_ReadData1 = byp1 ? WB_WriteData : arr_rd1;
        ID_ReadData2 = byp2 ? WB_WriteData : arr_rd2;
    end
`else
    always_comb begin
        ID_ReadData1 = arr_rd1;
        ID_ReadData2 = arr_rd2;
    end
`endif

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage plus architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs and selects the write-back value (load data or ALU result). It commits that value to a 32x32 register file, which the ID stage reads through two combinational read ports. The selected write-back value is also exported to the EX-stage forwarding unit.

Parameters:
DATA_WIDTH, 32, register and data-path width in bits
NUM_REGS, 32, number of architectural registers
ADDR_WIDTH, 5, register index width; must satisfy 2**ADDR_WIDTH == NUM_REGS

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
WB_ReadData  input  DATA_WIDTH  load data from the MEM/WB register
WB_ALU_result  input  DATA_WIDTH  ALU result from the MEM/WB register
WB_RegDest  input  ADDR_WIDTH  destination register index
WB_MemtoReg  input  1  1 selects WB_ReadData, 0 selects WB_ALU_result
WB_RegWrite  input  1  write enable
ID_ReadReg1  input  ADDR_WIDTH  read port 1 index (rs)
ID_ReadReg2  input  ADDR_WIDTH  read port 2 index (rt)
ID_ReadData1  output  DATA_WIDTH  read port 1 data
ID_ReadData2  output  DATA_WIDTH  read port 2 data
WB_WriteData  output  DATA_WIDTH  selected write-back value, for forwarding

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. Nothing changes state except on the rising edge of clk.
- Write-back mux: WB_WriteData = WB_MemtoReg ? WB_ReadData : WB_ALU_result. This path is purely combinational and is independent of rst.
- Reset: at a rising edge with rst=1, all NUM_REGS entries clear to 0. Any write presented in that same cycle is discarded.
- Write: at a rising edge with rst=0, WB_RegWrite=1 and WB_RegDest!=0, entry[WB_RegDest] <= WB_WriteData. Write latency is 1 cycle; the new value is visible on the read ports in the following cycle.
- Register $zero: entry 0 is never written and always reads 0, including through any bypass path.
- WB_RegWrite=0: the array holds its value. WB_RegDest, WB_MemtoReg and both data inputs are don't-care.
- Reads: ID_ReadDataN = entry[ID_ReadRegN], combinational (asynchronous read).
- Output values after reset: ID_ReadData1 and ID_ReadData2 read 0 for every index from the cycle after the reset edge until the first write.
- Same-cycle read and write to the same index (macro absent): the read returns the old value. The hazard unit is responsible for this case.
- Both read ports addressing the same index: both return the identical value.
- X handling: X on WB_RegDest while WB_RegWrite=0 must not corrupt the array.
- Reset mid-operation: a write in flight on the reset edge is lost. The pipeline is refilled from reset state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-through bypass. ID_ReadDataN = WB_WriteData when all of the following hold in the same cycle:
  - WB_RegWrite=1
  - WB_RegDest!=0
  - WB_RegDest==ID_ReadRegN
  - rst=0
  Otherwise ID_ReadDataN is the array value. This models the classic write-first-half / read-second-half behaviour.
- Undefined: no bypass. Reads always return array contents, with the old-value behaviour described above.

Decomposition:
- Shared package mips_pkg holds DATA_WIDTH, ADDR_WIDTH and NUM_REGS defaults, plus constant REG_ZERO = 0.
- One natural sub-module: wb_mux, the 2:1 write-back select driving WB_WriteData.
- The storage array, reset, write logic and read/bypass logic stay in wb_regfile.

Test Plan:
- Reset: rst=1 for 2 cycles, then read indices 0..31 on both ports -> all 0.
- ALU write: WB_RegWrite=1, MemtoReg=0, RegDest=5, ALU_result=0x0000_1234 -> ID_ReadData1 with ReadReg1=5 is 0x0000_1234 next cycle; WB_WriteData=0x0000_1234 in the same cycle.
- Load write: MemtoReg=1, ReadData=0xDEAD_BEEF, ALU_result=0x1, RegDest=31 -> entry 31 = 0xDEAD_BEEF; ReadReg1=ReadReg2=31 both return 0xDEAD_BEEF.
- $zero protection: RegWrite=1, RegDest=0, data=0xFFFF_FFFF -> reads of index 0 return 0, both same cycle (under REGFILE_BYPASS_EN) and next cycle.
- Same-cycle hazard: r7=0x11; then write r7=0x22 while ReadReg2=7 -> ID_ReadData2=0x11 without the macro, 0x22 with REGFILE_BYPASS_EN; 0x22 in both builds next cycle.
- Reset mid-operation: r3=0xAA; then rst=1 with RegWrite=1, RegDest=3, data=0xBB -> after the edge, r3 reads 0, and with the macro, no bypass of 0xBB during the rst=1 cycle.
